control_sequencer: RTL and testbench



---
 rtl/control_sequencer.sv | 113 +++++++++++
 tb/tb_control_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute micro-sequencer producing the 16-bit datapath control word.
// Memory micro-steps (FETCH2, RD2, ST3) stall until mem_ready is high.
module control_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       ir_opcode,
    input  logic             acc_sign,
    input  logic             mem_ready,
    output logic [15:0]      control_signals,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_JMP   = 8'h05;
    localparam logic [7:0] OP_JGEZ  = 8'h06;
    localparam logic [7:0] OP_HALT  = 8'h07;

    typedef enum logic [3:0] {
        S_INIT, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_RD1, S_RD2, S_RD3, S_RD4,
        S_ST1, S_ST2, S_ST3,
        S_JMP, S_RETIRE, S_HALT
    } state_t;

    state_t     state;
    logic [7:0] op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_INIT;
            op_q        <= '0;
            instr_count <= '0;
        end else begin
            case (state)
                S_INIT:   state <= S_FETCH1;
                S_FETCH1: state <= S_FETCH2;
                S_FETCH2: if (mem_ready) state <= S_FETCH3;
                S_FETCH3: state <= S_DECODE;
                S_DECODE: begin
                    op_q <= ir_opcode;
                    case (ir_opcode)
                        OP_LOAD, OP_ADD, OP_SUB: state <= S_RD1;
                        OP_STORE:                state <= S_ST1;
                        OP_JMP, OP_JGEZ:         state <= S_JMP;
                        OP_HALT: begin
                            state       <= S_HALT;
                            instr_count <= instr_count + CNT_W'(1);
                        end
                        default:                 state <= S_RETIRE;
                    endcase
                end
                S_RD1:    state <= S_RD2;
                S_RD2:    if (mem_ready) state <= S_RD3;
                S_RD3:    state <= S_RD4;
                S_RD4:    state <= S_RETIRE;
                S_ST1:    state <= S_ST2;
                S_ST2:    state <= S_ST3;
                S_ST3:    if (mem_ready) state <= S_RETIRE;
                S_JMP:    state <= S_RETIRE;
                S_RETIRE: begin
                    state       <= S_FETCH1;
                    instr_count <= instr_count + CNT_W'(1);
                end
                S_HALT:   state <= S_HALT;
                default:  state <= S_INIT;
            endcase
        end
    end

    // Combinational from state so an async reset clears every control bit at once.
    always_comb begin
        control_signals = '0;
        case (state)
            S_FETCH1: control_signals[0] = 1'b1;
            S_FETCH2: begin
                control_signals[2] = 1'b1;
                control_signals[1] = mem_ready;
                control_signals[5] = mem_ready;
            end
            S_FETCH3: control_signals[3] = 1'b1;
            S_RD1:    control_signals[4] = 1'b1;
            S_RD2: begin
                control_signals[2] = 1'b1;
                control_signals[5] = mem_ready;
            end
            S_RD3:    control_signals[6] = 1'b1;
            S_RD4: begin
                control_signals[9] = (op_q == OP_LOAD);
                control_signals[7] = (op_q == OP_ADD);
                control_signals[8] = (op_q == OP_SUB);
            end
            S_ST1:    control_signals[4]  = 1'b1;
            S_ST2:    control_signals[10] = 1'b1;
            S_ST3:    control_signals[11] = 1'b1;
            S_JMP:    control_signals[12] = (op_q == OP_JMP) || (op_q == OP_JGEZ && !acc_sign);
            S_HALT:   control_signals[14] = 1'b1;
            default:  control_signals = '0;
        endcase
    end

    assign halted = (state == S_HALT);

    logic unused_nop;
    assign unused_nop = (OP_NOP == 8'h00);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboarded bench for control_sequencer: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_control_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ir_opcode;
    logic        acc_sign;
    logic        mem_ready;
    logic [15:0] control_signals;
    logic        halted;
    logic [15:0] instr_count;

    control_sequencer #(.CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ir_opcode       (ir_opcode),
        .acc_sign        (acc_sign),
        .mem_ready       (mem_ready),
        .control_signals (control_signals),
        .halted          (halted),
        .instr_count     (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ctrl;
        logic        halt;
        logic [15:0] cnt;
        int          id;
    } exp_t;

    exp_t        sb[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          step_no = 0;
    logic [15:0] exp_cnt = '0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_total++;
            if (control_signals === e.ctrl) n_pass++;
            else $display("FAIL ctrl step %0d: got %04h expected %04h", e.id, control_signals, e.ctrl);
            n_total++;
            if (halted === e.halt) n_pass++;
            else $display("FAIL halted step %0d: got %0b expected %0b", e.id, halted, e.halt);
            n_total++;
            if (instr_count === e.cnt) n_pass++;
            else $display("FAIL count step %0d: got %0d expected %0d", e.id, instr_count, e.cnt);
        end
    end

    task automatic step(input logic mr, input logic [7:0] op, input logic sg,
                        input logic [15:0] ec, input logic eh);
        mem_ready = mr;
        ir_opcode = op;
        acc_sign  = sg;
        sb.push_back('{ctrl: ec, halt: eh, cnt: exp_cnt, id: step_no});
        step_no++;
        @(posedge clk);
        #1;
    endtask

    // Asserted mid-cycle: the check lands before any clock edge, so it sees the async clear.
    task automatic do_reset();
        rst_n   = 1'b0;
        exp_cnt = '0;
        step(1'b1, 8'h07, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 8'h07, 1'b0, 16'h0000, 1'b0);
        rst_n = 1'b1;
        step(1'b1, 8'h00, 1'b0, 16'h0000, 1'b0);  // INIT
    endtask

    task automatic fetch(input int waits);
        step(1'b1, 8'h00, 1'b0, 16'h0001, 1'b0);
        for (int i = 0; i < waits; i++) step(1'b0, 8'h00, 1'b0, 16'h0004, 1'b0);
        step(1'b1, 8'h00, 1'b0, 16'h0026, 1'b0);
        step(1'b1, 8'h00, 1'b0, 16'h0008, 1'b0);
    endtask

    task automatic retire();
        step(1'b1, 8'h00, 1'b0, 16'h0000, 1'b0);
        exp_cnt++;
    endtask

    task automatic alu_op(input logic [7:0] op, input logic [15:0] rd4, input int waits);
        fetch(0);
        step(1'b1, op, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 8'h00, 1'b0, 16'h0010, 1'b0);
        for (int i = 0; i < waits; i++) step(1'b0, 8'h00, 1'b0, 16'h0004, 1'b0);
        step(1'b1, 8'h00, 1'b0, 16'h0024, 1'b0);
        step(1'b1, 8'h00, 1'b0, 16'h0040, 1'b0);
        step(1'b1, 8'h00, 1'b0, rd4, 1'b0);
        retire();
    endtask

    task automatic jump(input logic [7:0] op, input logic sg, input logic [15:0] ej);
        fetch(0);
        step(1'b1, op, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 8'h00, sg, ej, 1'b0);
        retire();
    endtask

    initial begin
        rst_n     = 1'b0;
        ir_opcode = '0;
        acc_sign  = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // NOP with and without fetch wait states
        fetch(0);
        step(1'b1, 8'h00, 1'b0, 16'h0000, 1'b0);
        retire();
        fetch(3);
        step(1'b1, 8'h00, 1'b0, 16'h0000, 1'b0);
        retire();

        alu_op(8'h03, 16'h0080, 0);
        alu_op(8'h04, 16'h0100, 0);
        alu_op(8'h01, 16'h0200, 1);

        // STORE with two ST3 wait cycles
        fetch(0);
        step(1'b1, 8'h02, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 8'h00, 1'b0, 16'h0010, 1'b0);
        step(1'b1, 8'h00, 1'b0, 16'h0400, 1'b0);
        step(1'b0, 8'h00, 1'b0, 16'h0800, 1'b0);
        step(1'b0, 8'h00, 1'b0, 16'h0800, 1'b0);
        step(1'b1, 8'h00, 1'b0, 16'h0800, 1'b0);
        retire();

        jump(8'h06, 1'b0, 16'h1000);
        jump(8'h06, 1'b1, 16'h0000);
        jump(8'h05, 1'b1, 16'h1000);

        fetch(0);
        step(1'b1, 8'hA5, 1'b0, 16'h0000, 1'b0);
        retire();

        // Reset in the middle of an RD2 wait
        fetch(0);
        step(1'b1, 8'h01, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 8'h00, 1'b0, 16'h0010, 1'b0);
        step(1'b0, 8'h00, 1'b0, 16'h0004, 1'b0);
        do_reset();

        fetch(0);
        step(1'b1, 8'h07, 1'b0, 16'h0000, 1'b0);
        exp_cnt++;
        for (int i = 0; i < 5; i++) step(i[0], 8'h00, 1'b1, 16'h4000, 1'b1);
        do_reset();
        fetch(0);

        @(negedge clk);
        #1;
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
